// File: rtl/serial_sub_nbit_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
// master drives operands and start; slave returns status and results.
interface serial_sub_nbit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_sub_nbit.sv
// Bit-serial a - b, LSB first, one bit per clock through a single
// full-subtractor cell with a registered borrow.

module serial_sub_bit_cell (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic d,
  output logic br_next
);
  always_comb begin
    d       = x ^ y ^ br;
    br_next = (~x & y) | (~(x ^ y) & br);
  end
endmodule

module serial_sub_nbit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_sub_nbit_if.slave     bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic cell_d;
  logic cell_br_next;

  serial_sub_bit_cell u_cell (
    .x       (sa_q[0]),
    .y       (sb_q[0]),
    .br      (borrow_q),
    .d       (cell_d),
    .br_next (cell_br_next)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sa_d     = bus.a;
          sb_d     = bus.b;
          // operand MSBs kept aside: sa/sb are consumed by the shift
          a_msb_d  = bus.a[WIDTH-1];
          b_msb_d  = bus.b[WIDTH-1];
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        sr_d     = {cell_d, sr_q[WIDTH-1:1]};
        borrow_d = cell_br_next;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // last bit: publish all results on the same edge
          diff_d  = sr_d;
          bout_d  = cell_br_next;
          ovf_d   = (a_msb_q != b_msb_q) & (cell_d != a_msb_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    bus.busy = (state_q == S_RUN) || (state_q == S_DONE);
    bus.done = (state_q == S_DONE);
    bus.diff = diff_q;
    bus.bout = bout_q;
    bus.ovf  = ovf_q;
  end
endmodule

// File: tb/tb_serial_sub_nbit.sv
// Directed bench for serial_sub_nbit at WIDTH=8 with hand-computed results.
module tb_serial_sub_nbit;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  serial_sub_nbit_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_nbit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one op, wait for done; edges counts clock edges after the start edge.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        output int edges, output int busy_n);
    bus.a = ta;
    bus.b = tb_v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    edges = 0;
    busy_n = 0;
    while (!bus.done && edges < 40) begin
      if (bus.busy) busy_n++;
      tick();
      edges++;
    end
    if (bus.busy) busy_n++;
    check("done_timeout", 32'(edges < 40), 32'd1);
  endtask

  task automatic op_and_check(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                              input logic [7:0] ed, input logic eb, input logic eo);
    int e, bn;
    run_op(ta, tb_v, e, bn);
    check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
    check({tag, "_bout"}, 32'(bus.bout), 32'(eb));
    check({tag, "_ovf"},  32'(bus.ovf),  32'(eo));
    tick();
    check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int e, bn, ndone;
    bus.start = 1'b1;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    rst = 1'b1;

    // reset held with start asserted: stays idle
    tick();
    check("rst_busy0", 32'(bus.busy), 32'd0);
    tick();
    check("rst_busy1", 32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_diff",  32'(bus.diff), 32'h00);
    check("rst_bout",  32'(bus.bout), 32'd0);
    check("rst_ovf",   32'(bus.ovf),  32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_after_rst", 32'(bus.busy), 32'd0);

    // latency and busy width: done visible after the 8th edge following the start edge
    run_op(8'h5A, 8'h13, e, bn);
    check("lat_edges", 32'(e), 32'd8);
    check("busy_cycles", 32'(bn), 32'd9);
    check("5A_13_diff", 32'(bus.diff), 32'h47);
    check("5A_13_bout", 32'(bus.bout), 32'd0);
    check("5A_13_ovf",  32'(bus.ovf),  32'd0);
    tick();
    check("post_done_busy", 32'(bus.busy), 32'd0);
    check("post_done_done", 32'(bus.done), 32'd0);
    check("hold_diff", 32'(bus.diff), 32'h47);

    op_and_check("13_5A", 8'h13, 8'h5A, 8'hB9, 1'b1, 1'b0);
    op_and_check("00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    op_and_check("80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op_and_check("7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // start pulsed mid-run is ignored
    bus.a = 8'h5A;
    bus.b = 8'h13;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.a = 8'hFF;
    bus.b = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        ndone++;
        check("ign_diff", 32'(bus.diff), 32'h47);
        check("ign_bout", 32'(bus.bout), 32'd0);
      end
      tick();
    end
    check("ign_one_done", 32'(ndone), 32'd1);
    check("ign_idle", 32'(bus.busy), 32'd0);

    // reset at count==4 abandons the op
    bus.a = 8'h13;
    bus.b = 8'h5A;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_diff", 32'(bus.diff), 32'h00);
    check("mrst_bout", 32'(bus.bout), 32'd0);
    check("mrst_ovf",  32'(bus.ovf),  32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) ndone++;
      tick();
    end
    check("mrst_no_done", 32'(ndone), 32'd0);

    op_and_check("10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
